// File: rtl/conv_frame_sequencer.sv
// rtl/conv_frame_sequencer.sv - frame sequencer for the 3x3 line-buffer convolution datapath
module conv_frame_sequencer #(
  parameter int WORD_SIZE = 8,
  parameter int ROW_SIZE  = 540,
  parameter int NUM_ROWS  = 480,
  parameter int DP_LAT    = 4,
  localparam int XW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1,
  localparam int YW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_pixel,
  output logic                 dp_rst,
  output logic                 dp_en,
  output logic [WORD_SIZE-1:0] dp_pixel,
  input  logic [WORD_SIZE-1:0] dp_result,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] out_pixel,
  output logic [XW-1:0]        out_x,
  output logic [YW-1:0]        out_y,
  output logic                 out_border,
  output logic                 out_last
);

  // Step counter spans every enabled datapath step of one frame (feed + flush).
  localparam int SW        = $clog2(ROW_SIZE * NUM_ROWS + ROW_SIZE + DP_LAT + 2);
  localparam int LAT_INT   = ROW_SIZE + 1 + DP_LAT;
  localparam int TOTAL_INT = ROW_SIZE * NUM_ROWS + LAT_INT;

  // First step whose result belongs to raster index 0.
  localparam logic [SW-1:0] LAT_STEPS = SW'(LAT_INT);
  // Step index of the last real pixel accept.
  localparam logic [SW-1:0] FEED_LAST = SW'(ROW_SIZE * NUM_ROWS - 1);
  // Step index of the final flush step; it also carries the last output.
  localparam logic [SW-1:0] STEP_LAST = SW'(TOTAL_INT - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(ROW_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [SW-1:0]        r_s;
  logic [XW-1:0]        r_x;
  logic [YW-1:0]        r_y;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_out_valid;
  logic [WORD_SIZE-1:0] r_out_pixel;
  logic [XW-1:0]        r_out_x;
  logic [YW-1:0]        r_out_y;
  logic                 r_out_border;
  logic                 r_out_last;

  logic w_accept;
  logic w_step;
  logic w_emit;
  logic w_x_last;
  logic w_y_last;
  logic w_border;

  // The step counter doubles as the feed counter: during FEED every step is an accept.
  assign w_accept = (r_state == S_FEED) && in_valid;
  assign w_step   = w_accept || (r_state == S_FLUSH);
  assign w_emit   = w_step && (r_s >= LAT_STEPS);
  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);
  assign w_border = (r_x == '0) || w_x_last || (r_y == '0) || w_y_last;

  assign in_ready   = (r_state == S_FEED);
  assign dp_rst     = (r_state == S_CLEAR);
  assign dp_en      = w_step;
  assign dp_pixel   = w_accept ? in_pixel : '0;
  assign busy       = r_busy;
  assign done       = r_done;
  assign out_valid  = r_out_valid;
  assign out_pixel  = r_out_pixel;
  assign out_x      = r_out_x;
  assign out_y      = r_out_y;
  assign out_border = r_out_border;
  assign out_last   = r_out_last;

  // Frame FSM, step/coordinate counters and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_s          <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_pixel  <= '0;
      r_out_x      <= '0;
      r_out_y      <= '0;
      r_out_border <= 1'b0;
      r_out_last   <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;

      if (w_step) begin
        r_s <= r_s + SW'(1);
      end

      // Result at this step belongs to the coordinate held in r_x/r_y.
      if (w_emit) begin
        r_out_valid  <= 1'b1;
        r_out_x      <= r_x;
        r_out_y      <= r_y;
        r_out_border <= w_border;
        r_out_pixel  <= w_border ? '0 : dp_result;
        r_out_last   <= w_x_last && w_y_last;
        if (w_x_last) begin
          r_x <= '0;
          r_y <= w_y_last ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_CLEAR;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_s     <= '0;
          r_x     <= '0;
          r_y     <= '0;
          r_state <= S_FEED;
        end
        S_FEED: begin
          if (w_accept && (r_s == FEED_LAST)) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (r_s == STEP_LAST) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb/tb_conv_frame_sequencer.sv - randomized self-checking bench for conv_frame_sequencer
module tb_conv_frame_sequencer;

  localparam int R    = 4;
  localparam int N    = 3;
  localparam int LAT  = 4;
  localparam int W    = 8;
  localparam int L    = R + 1 + LAT;
  localparam int NPIX = R * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         busy;
  logic         done;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_pixel;
  logic         dp_rst;
  logic         dp_en;
  logic [W-1:0] dp_pixel;
  logic [W-1:0] dp_result;
  logic         out_valid;
  logic [W-1:0] out_pixel;
  logic [1:0]   out_x;
  logic [1:0]   out_y;
  logic         out_border;
  logic         out_last;

  always #5 clk = ~clk;

  conv_frame_sequencer #(
    .WORD_SIZE(W),
    .ROW_SIZE (R),
    .NUM_ROWS (N),
    .DP_LAT   (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .dp_rst    (dp_rst),
    .dp_en     (dp_en),
    .dp_pixel  (dp_pixel),
    .dp_result (dp_result),
    .out_valid (out_valid),
    .out_pixel (out_pixel),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_border(out_border),
    .out_last  (out_last)
  );

  // Datapath stand-in: pure delay of L enabled steps, cleared by dp_rst.
  logic [W-1:0] dly [L];
  always @(posedge clk) begin
    if (dp_rst) begin
      for (int i = 0; i < L; i++) dly[i] <= '0;
    end else if (dp_en) begin
      dly[0] <= dp_pixel;
      for (int i = 1; i < L; i++) dly[i] <= dly[i-1];
    end
  end
  assign dp_result = dly[L-1];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Observation counters, cleared at the start of each frame.
  int cyc = 0;
  int n_rst_cyc, n_ready, n_en_feed, n_en_bad, n_flush, n_flush_nz;
  int n_done, n_orphan, last_cyc, done_cyc;
  int coord_q[$];
  int pix_q[$];
  logic prev_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dp_rst) n_rst_cyc++;
    if (in_ready) n_ready++;
    if (dp_en && in_ready) begin
      n_en_feed++;
      if (!in_valid) n_en_bad++;
    end
    if (dp_en && !in_ready) begin
      n_flush++;
      if (dp_pixel != '0) n_flush_nz++;
    end
    if (out_valid) begin
      if (!prev_en) n_orphan++;
      coord_q.push_back(int'(out_x) | (int'(out_y) << 4) | (int'(out_border) << 8) | (int'(out_last) << 12));
      pix_q.push_back(int'(out_pixel));
      if (out_last) last_cyc = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    prev_en = dp_en;
  end

  task automatic clear_obs();
    n_rst_cyc = 0; n_ready = 0; n_en_feed = 0; n_en_bad = 0;
    n_flush = 0; n_flush_nz = 0; n_done = 0; n_orphan = 0;
    last_cyc = -1; done_cyc = -2;
    coord_q.delete();
    pix_q.delete();
  endtask

  // gap_mode: 0 = in_valid always high, 1 = toggling, 2 = random gaps.
  task automatic run_frame(input string name, input int gap_mode, input bit mid_start, input bit fixed_pix);
    logic [W-1:0] pix [NPIX];
    int idx;
    int budget;
    bit acc;
    int x, y, b, lst, exp_pix;
    for (int p = 0; p < NPIX; p++) pix[p] = fixed_pix ? W'(p + 1) : W'($urandom_range(1, 255));
    clear_obs();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({name, " busy_after_start"}, int'(busy), 1);
    idx = 0;
    budget = 0;
    while (idx < NPIX && budget < 200) begin
      if (gap_mode == 0) in_valid = 1'b1;
      else if (gap_mode == 1) in_valid = (budget % 2 == 0);
      else in_valid = ($urandom_range(0, 2) != 0);
      in_pixel = pix[idx];
      start = (mid_start && idx == 5);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      budget++;
    end
    in_valid = 1'b0;
    in_pixel = '0;
    start = 1'b0;
    check({name, " feed_accepts"}, idx, NPIX);
    budget = 0;
    while (n_done == 0 && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    @(negedge clk);
    check({name, " done_seen"}, n_done, 1);
    check({name, " done_one_cycle"}, int'(done), 0);
    check({name, " busy_low"}, int'(busy), 0);
    check({name, " done_after_last"}, done_cyc, last_cyc + 1);
    check({name, " dp_rst_cycles"}, n_rst_cyc, 1);
    if (gap_mode == 0) check({name, " in_ready_cycles"}, n_ready, NPIX);
    check({name, " dp_en_accepts"}, n_en_feed, NPIX);
    check({name, " dp_en_no_valid"}, n_en_bad, 0);
    check({name, " flush_steps"}, n_flush, L);
    check({name, " flush_nonzero"}, n_flush_nz, 0);
    check({name, " out_orphans"}, n_orphan, 0);
    check({name, " out_count"}, coord_q.size(), NPIX);
    for (int p = 0; p < NPIX && p < coord_q.size(); p++) begin
      x = p % R;
      y = p / R;
      b = (x == 0 || x == R - 1 || y == 0 || y == N - 1) ? 1 : 0;
      lst = (p == NPIX - 1) ? 1 : 0;
      exp_pix = b ? 0 : int'(pix[p]);
      check($sformatf("%s out%0d coord", name, p), coord_q[p], x | (y << 4) | (b << 8) | (lst << 12));
      check($sformatf("%s out%0d pixel", name, p), pix_q[p], exp_pix);
    end
  endtask

  initial begin
    int idx;
    int budget;
    bit acc;
    rst = 1'b1;
    start = 1'b1;
    in_valid = 1'b0;
    in_pixel = '0;
    clear_obs();
    repeat (2) begin
      @(negedge clk);
      check("rst busy", int'(busy), 0);
      check("rst done", int'(done), 0);
      check("rst in_ready", int'(in_ready), 0);
      check("rst dp_en", int'(dp_en), 0);
      check("rst out_valid", int'(out_valid), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("post_rst idle busy", int'(busy), 0);
    check("post_rst idle dp_rst", int'(dp_rst), 0);

    run_frame("f_full", 0, 1'b0, 1'b1);
    run_frame("f_toggle", 1, 1'b0, 1'b1);
    run_frame("f_midstart", 2, 1'b1, 1'b0);
    run_frame("f_second", 0, 1'b0, 1'b0);

    // Abort a frame after six accepts.
    clear_obs();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    idx = 0;
    budget = 0;
    while (idx < 6 && budget < 100) begin
      in_valid = 1'b1;
      in_pixel = W'($urandom_range(1, 255));
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      budget++;
    end
    check("abort accepts", idx, 6);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort in_ready", int'(in_ready), 0);
    check("abort busy", int'(busy), 0);
    coord_q.delete();
    pix_q.delete();
    in_valid = 1'b1;
    repeat (20) @(posedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("abort no_outputs", coord_q.size(), 0);
    check("abort no_dp_en", n_en_feed + n_flush > 6 ? 1 : 0, 0);

    run_frame("f_after_abort", 2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
Frame-level controller for the 3x3 line-buffer convolution datapath. It accepts a raster pixel stream over a valid/ready handshake and clears the datapath before each frame. It gates the datapath with a step enable, then feeds zero pixels to flush the last rows and the pipeline. It realigns the datapath results to output coordinates, masks the invalid border ring, and signals frame completion.

Parameters:
WORD_SIZE, 8, pixel width
ROW_SIZE, 540, pixels per row (R)
NUM_ROWS, 480, rows per frame (N)
DP_LAT, 4, datapath pipeline depth in enabled steps (window, product, sum, clamp)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begins a frame when idle
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last output
in_valid  in  1  upstream pixel valid
in_ready  out  1  sequencer accepts pixel
in_pixel  in  WORD_SIZE  upstream pixel
dp_rst  out  1  datapath synchronous clear
dp_en  out  1  datapath advances one step this cycle
dp_pixel  out  WORD_SIZE  pixel driven to datapath
dp_result  in  WORD_SIZE  datapath clamped output
out_valid  out  1  output pixel valid (1 cycle)
out_pixel  out  WORD_SIZE  result, 0 on border
out_x  out  clog2(R)  output column
out_y  out  clog2(N)  output row
out_border  out  1  output lies on the frame edge
out_last  out  1  final pixel of frame

Behaviour:
- Reset: state IDLE. All outputs 0, including busy, done, in_ready, dp_en, dp_rst, out_*.
- States: IDLE -> CLEAR -> FEED -> FLUSH -> DONE -> IDLE.
- IDLE: start=1 -> CLEAR, busy<=1. start while not IDLE is ignored.
- CLEAR: one cycle with dp_rst=1, dp_en=0. Next state is FEED; the step counter s and the feed counter are zeroed.
- FEED:
  - in_ready=1.
  - in_valid&in_ready -> dp_en=1 and dp_pixel=in_pixel, combinational in the same cycle. s and the feed counter increment.
  - No accept -> dp_en=0, datapath holds.
  - After R*N accepts -> FLUSH; in_ready drops the cycle after the last accept.
- FLUSH: dp_en=1 and dp_pixel=0 every cycle for R+1+DP_LAT steps, then DONE.
- Alignment: the output for raster index p = s-(R+1+DP_LAT) is dp_result sampled at enabled step s, for s >= R+1+DP_LAT and p < R*N.
- Output registers: on such a step, the following are registered for the next cycle:
  - out_valid=1
  - out_x = p mod R, out_y = p div R, tracked as wrap counters with no divider
  - out_border = (x==0 | x==R-1 | y==0 | y==N-1)
  - out_pixel = out_border ? 0 : dp_result
  - out_last = (p == R*N-1)
- Otherwise out_valid=0 and the other out_* hold their last values.
- DONE: done=1 for exactly one cycle, co-timed with the cycle after the out_last cycle; busy<=0; return to IDLE.
- Counters: s has width clog2(R*N+R+DP_LAT+2). x wraps R-1->0 and increments y; y at N-1 with x at R-1 ends the frame. Counters never roll over mid-frame.
- Output rate: exactly R*N out_valid pulses per frame and no duplicates. in_valid gaps only delay outputs and never reorder them.
- There is no output backpressure; the consumer must accept one pixel per cycle.
- rst mid-frame: immediate return to IDLE and outputs cleared. The partial frame is discarded; the next start re-clears the datapath.
- in_valid outside FEED is ignored (in_ready=0) and no pixel is consumed.

Test Plan:
Bench setup: R=4, N=3, DP_LAT=4, datapath model = (dp_pixel) delayed by R+1+DP_LAT enabled steps, cleared by dp_rst.
1. Assert rst 2 cycles with start=1 -> busy, done, in_ready, dp_en, out_valid all 0; state stays IDLE.
2. start pulse, in_valid held high, pixels 1..12:
   - dp_rst high exactly 1 cycle; in_ready high 12 cycles; then 9 flush steps with dp_pixel=0.
   - 12 out_valid pulses with (x,y) in raster order.
   - out_border=0 only at p=5,6, where out_pixel=6,7; all others out_pixel=0.
   - out_last at p=11; done 1 cycle later, busy falls.
3. Same frame with in_valid toggling every other cycle -> dp_en high only on accepts; identical 12-output sequence and values; no out_valid during stalls.
4. start pulsed mid-FEED -> ignored; frame completes normally. A second start after done -> CLEAR again and a full second frame is correct.
5. rst asserted after 6 accepts -> next cycle IDLE, in_ready=0, no further out_valid. A fresh start yields a correct complete frame with no residue.
